// File: rtl/flag_stack_if.sv
// Flag stack unit bus: ALU flag inputs, stack controls, condition select and status.
interface flag_stack_if #(
    parameter int unsigned NFLAGS      = 4,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned SELW = $clog2(NFLAGS) + 1;
    localparam int unsigned DW   = $clog2(STACK_DEPTH + 1);

    logic [NFLAGS-1:0] din;
    logic [NFLAGS-1:0] we_mask;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [SELW-1:0]   sel;
    logic              flag_out;
    logic [NFLAGS-1:0] flags;
    logic [DW-1:0]     depth;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output din, we_mask, push, pop, err_clr, sel,
        input  flag_out, flags, depth, stack_full, stack_empty, err_ovf, err_udf
    );

    modport slave (
        input  din, we_mask, push, pop, err_clr, sel,
        output flag_out, flags, depth, stack_full, stack_empty, err_ovf, err_udf
    );
endinterface

// File: rtl/flag_stack_unit.sv
// Condition flag register with per-flag write enables, branch condition select and a LIFO save stack.
// Define FLAG_BYPASS_EN to evaluate flag_out on the same-cycle forwarded flag vector.
module flag_stack_unit #(
    parameter int unsigned NFLAGS      = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    flag_stack_if.slave  bus
);
    localparam int unsigned SELW = $clog2(NFLAGS) + 1;
    localparam int unsigned IW   = SELW - 1;
    localparam int unsigned DW   = $clog2(STACK_DEPTH + 1);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NFLAGS-1:0] wr_val, top_val, eval_src;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              full, empty;
    logic              push_only, pop_only, push_ok, pop_ok;
    logic [IW-1:0]     idx;
    logic              base;
    logic [NFLAGS-1:0] stack_mem [STACK_DEPTH];

    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
        wr_val    = (flags_q & ~bus.we_mask) | (bus.din & bus.we_mask);
        push_only = bus.push & ~bus.pop;
        pop_only  = bus.pop & ~bus.push;
        push_ok   = push_only & ~full;
        pop_ok    = pop_only & ~empty;

        top_val = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i) == depth_q - DW'(1)) top_val = stack_mem[i];
        end

        // Pop alone suppresses the write; push+pop together behaves as a plain write.
        flags_d = wr_val;
        if (pop_only) flags_d = pop_ok ? top_val : flags_q;

        depth_d = depth_q;
        if (push_ok) depth_d = depth_q + DW'(1);
        if (pop_ok)  depth_d = depth_q - DW'(1);

        ovf_d = (ovf_q & ~bus.err_clr) | (push_only & full);
        udf_d = (udf_q & ~bus.err_clr) | (pop_only & empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Stack storage is not reset; a reset cycle simply blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (DW'(i) == depth_q) stack_mem[i] <= flags_q;
            end
        end
    end

    always_comb begin
        eval_src = flags_q;
`ifdef FLAG_BYPASS_EN
        if (rst_n && !bus.pop) eval_src = wr_val;
`endif
        idx  = bus.sel[SELW-2:0];
        base = 1'b0;
        for (int unsigned i = 0; i < NFLAGS; i++) begin
            if (idx == IW'(i)) base = eval_src[i];
        end
        bus.flag_out = base ^ bus.sel[SELW-1];
    end

    assign bus.flags       = flags_q;
    assign bus.depth       = depth_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err_ovf     = ovf_q;
    assign bus.err_udf     = udf_q;
endmodule

// File: tb/tb_flag_stack_unit.sv
// Scoreboard bench for flag_stack_unit (NFLAGS=4, STACK_DEPTH=4); honours FLAG_BYPASS_EN.
module tb_flag_stack_unit;
    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] we;
        logic       push;
        logic       pop;
        logic       clr;
    } step_t;

    typedef struct {
        logic [3:0] flags;
        logic [2:0] depth;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_ovf, m_udf;
    exp_t       sb[$];

    flag_stack_if #(.NFLAGS(4), .STACK_DEPTH(4)) bus ();

    flag_stack_unit #(.NFLAGS(4), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic step_t st(logic rst, logic [3:0] d, logic [3:0] we,
                                 logic pu, logic po, logic clr);
        step_t s;
        s.rst = rst; s.din = d; s.we = we; s.push = pu; s.pop = po; s.clr = clr;
        return s;
    endfunction

    // Drives one cycle, advances the reference model and queues the expected state.
    task automatic apply(input step_t s);
        exp_t       e;
        logic [3:0] wr;
        logic       n_ovf, n_udf;
        bus.din = s.din; bus.we_mask = s.we; bus.push = s.push;
        bus.pop = s.pop; bus.err_clr = s.clr; rst_n = ~s.rst;
        wr = (m_flags & ~s.we) | (s.din & s.we);
        n_ovf = 1'b0; n_udf = 1'b0;
        if (s.rst) begin
            m_flags = 4'h0; m_stack.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (s.push && !s.pop) begin
                if (m_stack.size() == 4) n_ovf = 1'b1;
                else m_stack.push_back(m_flags);
                m_flags = wr;
            end else if (s.pop && !s.push) begin
                if (m_stack.size() == 0) n_udf = 1'b1;
                else m_flags = m_stack.pop_back();
            end else begin
                m_flags = wr;
            end
            m_ovf = (m_ovf && !s.clr) || n_ovf;
            m_udf = (m_udf && !s.clr) || n_udf;
        end
        e.flags = m_flags;
        e.depth = 3'(m_stack.size());
        e.full  = (m_stack.size() == 4);
        e.empty = (m_stack.size() == 0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.din = '0; bus.we_mask = '0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.err_clr = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        step_t q[$];
        bus.sel = '0;
        q.push_back(st(1, 4'hF, 4'hF, 1, 0, 0));
        q.push_back(st(1, 4'h0, 4'h0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.stack_full !== e.full ||
                bus.stack_empty !== e.empty || bus.err_ovf !== e.ovf || bus.err_udf !== e.udf) begin
                miscompares++;
                $display("FAIL reset[%0d]: got flags=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, want flags=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
                         i, bus.flags, bus.depth, bus.stack_full, bus.stack_empty, bus.err_ovf, bus.err_udf,
                         e.flags, e.depth, e.full, e.empty, e.ovf, e.udf);
            end
        end
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            #1;
            vectors++;
            if (bus.flag_out !== (s >= 4)) begin
                miscompares++;
                $display("FAIL reset_sel %0d: got flag_out=%b want %b", s, bus.flag_out, (s >= 4));
            end
        end
        bus.sel = '0;
    endtask

    task automatic test_write();
        exp_t e;
        step_t q[$];
        q.push_back(st(0, 4'b1010, 4'b0011, 0, 0, 0));
        q.push_back(st(0, 4'hF, 4'h0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.flag_out !== e.flags[0]) begin
                miscompares++;
                $display("FAIL write[%0d]: got flags=%h depth=%0d flag_out=%b, want flags=%h depth=%0d flag_out=%b",
                         i, bus.flags, bus.depth, bus.flag_out, e.flags, e.depth, e.flags[0]);
            end
        end
        vectors++;
        if (bus.flags !== 4'b0010) begin
            miscompares++;
            $display("FAIL write_value: got flags=%h want 2", bus.flags);
        end
        bus.sel = 3'b001; #1;
        vectors++;
        if (bus.flag_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sel_c: got flag_out=%b want 1", bus.flag_out);
        end
        bus.sel = 3'b101; #1;
        vectors++;
        if (bus.flag_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sel_not_c: got flag_out=%b want 0", bus.flag_out);
        end
        bus.sel = '0;
    endtask

    task automatic test_push_pop_write();
        exp_t e;
        step_t q[$];
        q.push_back(st(0, 4'h5, 4'hF, 0, 0, 0));
        q.push_back(st(0, 4'hA, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'h0, 4'h0, 0, 1, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.stack_empty !== e.empty) begin
                miscompares++;
                $display("FAIL push_write[%0d]: got flags=%h depth=%0d empty=%b, want flags=%h depth=%0d empty=%b",
                         i, bus.flags, bus.depth, bus.stack_empty, e.flags, e.depth, e.empty);
            end
        end
        vectors++;
        if (bus.flags !== 4'h5 || bus.depth !== 3'd0) begin
            miscompares++;
            $display("FAIL push_write_restore: got flags=%h depth=%0d want 5/0", bus.flags, bus.depth);
        end
    endtask

    task automatic test_overflow_underflow();
        exp_t e;
        step_t q[$];
        q.push_back(st(0, 4'h1, 4'hF, 0, 0, 0));
        q.push_back(st(0, 4'h2, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'h3, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'h4, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 0));
        q.push_back(st(0, 4'h9, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'hF, 4'hF, 0, 1, 0));
        q.push_back(st(0, 4'h0, 4'h0, 0, 1, 0));
        q.push_back(st(0, 4'h0, 4'h0, 0, 1, 0));
        q.push_back(st(0, 4'h0, 4'h0, 0, 1, 0));
        q.push_back(st(0, 4'h6, 4'hF, 0, 1, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.stack_full !== e.full ||
                bus.stack_empty !== e.empty || bus.err_ovf !== e.ovf || bus.err_udf !== e.udf) begin
                miscompares++;
                $display("FAIL ovf_udf[%0d]: got flags=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, want flags=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
                         i, bus.flags, bus.depth, bus.stack_full, bus.stack_empty, bus.err_ovf, bus.err_udf,
                         e.flags, e.depth, e.full, e.empty, e.ovf, e.udf);
            end
        end
        vectors++;
        if (bus.flags !== 4'h1 || bus.err_ovf !== 1'b1 || bus.err_udf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_udf_final: got flags=%h ovf=%b udf=%b want 1/1/1", bus.flags, bus.err_ovf, bus.err_udf);
        end
    endtask

    task automatic test_push_pop_together();
        exp_t e;
        step_t q[$];
        q.push_back(st(0, 4'h0, 4'hF, 0, 0, 1));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 0));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 0));
        q.push_back(st(0, 4'h1, 4'h1, 1, 1, 0));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 0));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 0));
        q.push_back(st(0, 4'h0, 4'h0, 1, 0, 1));
        q.push_back(st(0, 4'h0, 4'h0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.stack_full !== e.full ||
                bus.err_ovf !== e.ovf || bus.err_udf !== e.udf) begin
                miscompares++;
                $display("FAIL push_and_pop[%0d]: got flags=%h depth=%0d full=%b ovf=%b udf=%b, want flags=%h depth=%0d full=%b ovf=%b udf=%b",
                         i, bus.flags, bus.depth, bus.stack_full, bus.err_ovf, bus.err_udf,
                         e.flags, e.depth, e.full, e.ovf, e.udf);
            end
        end
        vectors++;
        if (bus.depth !== 3'd4 || bus.err_ovf !== 1'b0 || bus.flags[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL push_and_pop_final: got depth=%0d ovf=%b f0=%b want 4/0/1", bus.depth, bus.err_ovf, bus.flags[0]);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        step_t q[$];
        q.push_back(st(1, 4'hF, 4'hF, 1, 0, 0));
        q.push_back(st(0, 4'hF, 4'hF, 0, 1, 1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            vectors++;
            if (bus.flags !== e.flags || bus.depth !== e.depth || bus.stack_empty !== e.empty ||
                bus.err_ovf !== e.ovf || bus.err_udf !== e.udf) begin
                miscompares++;
                $display("FAIL reset_abort[%0d]: got flags=%h depth=%0d empty=%b ovf=%b udf=%b, want flags=%h depth=%0d empty=%b ovf=%b udf=%b",
                         i, bus.flags, bus.depth, bus.stack_empty, bus.err_ovf, bus.err_udf,
                         e.flags, e.depth, e.empty, e.ovf, e.udf);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic want;
`ifdef FLAG_BYPASS_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        bus.sel = '0;
        bus.din = 4'h1; bus.we_mask = 4'h1;
        #1;
        vectors++;
        if (bus.flag_out !== want) begin
            miscompares++;
            $display("FAIL same_cycle_flag: got flag_out=%b want %b", bus.flag_out, want);
        end
        bus.pop = 1'b1;
        #1;
        vectors++;
        if (bus.flag_out !== 1'b0) begin
            miscompares++;
            $display("FAIL no_forward_on_pop: got flag_out=%b want 0", bus.flag_out);
        end
        bus.pop = 1'b0; rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.flag_out !== 1'b0) begin
            miscompares++;
            $display("FAIL no_forward_in_reset: got flag_out=%b want 0", bus.flag_out);
        end
        rst_n = 1'b1;
        apply(st(0, 4'h1, 4'h1, 0, 0, 0));
        e = sb.pop_front();
        vectors++;
        if (bus.flags !== e.flags || bus.flag_out !== 1'b1) begin
            miscompares++;
            $display("FAIL next_cycle_flag: got flags=%h flag_out=%b want flags=%h flag_out=1",
                     bus.flags, bus.flag_out, e.flags);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_flags = 4'h0; m_ovf = 1'b0; m_udf = 1'b0;
        rst_n = 1'b0;
        bus.din = '0; bus.we_mask = '0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.err_clr = 1'b0; bus.sel = '0;
        test_reset();
        test_write();
        test_push_pop_write();
        test_overflow_underflow();
        test_push_pop_together();
        test_reset_abort();
        apply(st(1, 4'h0, 4'h0, 0, 0, 0));
        void'(sb.pop_front());
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flag_stack_unit.md
Name: flag_stack_unit

Overview:
- Parametrised successor to the CPU's 2-bit condition flag register.
- Holds NFLAGS condition flags with per-flag write enables.
- Selects any flag, true or inverted, for branch evaluation.
- Adds a LIFO flag stack so flags can be saved and restored across calls and interrupts.
- Sits between the ALU flag outputs and the branch/control unit.

Parameters:
- NFLAGS, 4, number of flags (bit0=Z, bit1=C, bit2=N, bit3=V); legal range 2..16.
- STACK_DEPTH, 4, number of saved flag words; legal range 1..16.
- SELW, $clog2(NFLAGS)+1, select width (derived; MSB = invert).
- DW, $clog2(STACK_DEPTH+1), depth counter width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  NFLAGS  new flag values from the ALU.
- we_mask  in  NFLAGS  per-flag write enable.
- push  in  1  save the current flags onto the stack.
- pop  in  1  restore flags from the top of the stack.
- err_clr  in  1  clear the sticky error bits.
- sel  in  SELW  condition select: [SELW-2:0] = flag index, [SELW-1] = invert.
- flag_out  out  1  selected condition.
- flags  out  NFLAGS  live flag register.
- depth  out  DW  number of valid stack entries.
- stack_full  out  1  depth==STACK_DEPTH.
- stack_empty  out  1  depth==0.
- err_ovf  out  1  sticky: push attempted while full.
- err_udf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst_n low at a clk edge):
  - flags=0, depth=0, err_ovf=0, err_udf=0.
  - Stack contents are don't-care.
  - Reset overrides all other inputs.
  - Reset during any operation aborts it; no partial stack update.
- Write:
  - At the edge, flags[i] <= din[i] for every i with we_mask[i]=1.
  - All other bits hold.
  - we_mask=0 is a no-op.
- Push only (push=1, pop=0, not full):
  - stack[depth] <= flags as registered before this edge; depth+1.
  - A same-cycle write still updates the live flags, so the stack holds the pre-write value.
- Push when full:
  - Stack and depth unchanged; err_ovf <= 1.
  - The write still applies.
- Pop only (pop=1, push=0, not empty):
  - flags <= stack[depth-1]; depth-1.
  - Pop has priority over write: we_mask is ignored that cycle.
- Pop when empty:
  - flags unchanged, write ignored, err_udf <= 1.
- push=1 and pop=1 together:
  - Stack and depth unchanged, no error set.
  - The write applies normally.
- Errors:
  - err_ovf and err_udf are sticky until err_clr=1.
  - If err_clr and a new error occur in the same cycle, the new error wins (bit stays 1).
- Stack behaviour:
  - Latency of push and pop is 1 cycle.
  - depth never wraps and saturates within 0..STACK_DEPTH.
  - stack_full and stack_empty decode combinationally from registered depth.
- flag_out (combinational):
  - idx = sel[SELW-2:0]; base = (idx<NFLAGS) ? flags[idx] : 0.
  - flag_out = base ^ sel[SELW-1].
  - An out-of-range index therefore gives 0, or 1 when inverted.
- NFLAGS=2 with sel=2'b00..2'b11 reproduces the legacy encoding (f0, f1, !f0, !f1).

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- When defined, flag_out is evaluated on the forwarded flag vector:
  - Forwarded bit i = we_mask[i] ? din[i] : flags[i].
  - Forwarding applies only when pop=0 and rst_n=1.
  - A branch in the same cycle as the flag-setting instruction then sees the new value.
  - The flags output stays the registered value.
- When not defined, flag_out uses only the registered flags (1-cycle visibility latency).

Test Plan (NFLAGS=4, STACK_DEPTH=4, SELW=3):
- Reset then sel=3'b000..3'b111 -> flags=4'h0, depth=0, stack_empty=1; flag_out=0 for sel<4 and 1 for sel>=4.
- din=4'b1010, we_mask=4'b0011 from flags=0 -> flags=4'b0010; sel=3'b001 gives 1, sel=3'b101 gives 0.
- flags=4'h5: push with din=4'hA, we_mask=4'hF in the same cycle -> flags=4'hA, depth=1; next cycle pop -> flags=4'h5, depth=0.
- Four pushes of 4'h1, 4'h2, 4'h3, 4'h4, then a fifth push -> stack_full=1, depth=4, err_ovf=1; four pops return 4'h4, 4'h3, 4'h2, 4'h1; a fifth pop -> err_udf=1 and flags stays 4'h1.
- push and pop together at depth=2 with we_mask=4'h1, din=4'h1 -> depth=2, no error, flags[0]=1; err_clr with a concurrent overflow -> err_ovf stays 1.
- Macro defined, flags=0, din=4'h1, we_mask=4'h1, sel=0 -> flag_out=1 in the same cycle. Macro undefined -> flag_out=0 that cycle and 1 the next.
